// File: rtl/drp_master_fsm.sv
// Single-outstanding DRP master: one drpen pulse per request, waits for drprdy or times out.
// Optional DRP_SEL_SHADOW_EN keeps local shadows of the four selector words and serves their reads.
module drp_master_fsm #(
  parameter int unsigned AW_QUAD     = 9,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter logic [31:0] TO_PATTERN  = 32'hDEAD_DEAD
) (
  input  logic               drp_clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [AW_QUAD-1:0] req_addr,
  input  logic [31:0]        req_wdata,
  input  logic               req_we,
  input  logic               req_int_reg,
  output logic               rsp_valid,
  output logic [31:0]        rsp_rdata,
  output logic               rsp_timeout,
  output logic [AW_QUAD-1:0] drpaddr,
  output logic [31:0]        drpdi,
  output logic               drpwe,
  output logic               drpen,
  output logic               int_reg,
  input  logic [31:0]        drpdo,
  input  logic               drprdy,
  output logic               busy,
  output logic [15:0]        timeout_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_LOCAL, S_RESP} state_e;

  localparam logic [15:0] TERM = 16'(TIMEOUT_CYC - 1);

  state_e             state_q;
  logic               req_ready_q;
  logic               rsp_valid_q;
  logic [31:0]        rsp_rdata_q;
  logic               rsp_timeout_q;
  logic [AW_QUAD-1:0] drpaddr_q;
  logic [31:0]        drpdi_q;
  logic               drpwe_q;
  logic               drpen_q;
  logic               int_reg_q;
  logic [15:0]        timeout_cnt_q;
  logic [15:0]        wait_cnt_q;
  logic [15:0]        wait_cnt_d;
  logic               sel_hit;
  logic               local_path;

  assign sel_hit    = &drpaddr_q[AW_QUAD-1:2];
  // Compare the incremented count so the timeout response lands TIMEOUT_CYC cycles after drpen.
  assign wait_cnt_d = wait_cnt_q + 16'd1;

`ifdef DRP_SEL_SHADOW_EN
  logic [3:0][31:0] shadow_q;
  assign local_path = sel_hit;
`else
  assign local_path = sel_hit & drpwe_q;
`endif

  always_ff @(posedge drp_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_timeout_q <= 1'b0;
      drpaddr_q     <= '0;
      drpdi_q       <= '0;
      drpwe_q       <= 1'b0;
      drpen_q       <= 1'b0;
      int_reg_q     <= 1'b0;
      timeout_cnt_q <= '0;
      wait_cnt_q    <= '0;
`ifdef DRP_SEL_SHADOW_EN
      shadow_q      <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            drpaddr_q   <= req_addr;
            drpdi_q     <= req_wdata;
            drpwe_q     <= req_we;
            int_reg_q   <= req_int_reg;
            drpen_q     <= 1'b1;
            req_ready_q <= 1'b0;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          drpen_q    <= 1'b0;
          wait_cnt_q <= '0;
          state_q    <= local_path ? S_LOCAL : S_WAIT;
        end
        S_WAIT: begin
          if (drprdy) begin
            rsp_rdata_q   <= drpwe_q ? '0 : drpdo;
            rsp_timeout_q <= 1'b0;
            rsp_valid_q   <= 1'b1;
            state_q       <= S_RESP;
          end else if (wait_cnt_d == TERM) begin
            rsp_rdata_q   <= TO_PATTERN;
            rsp_timeout_q <= 1'b1;
            rsp_valid_q   <= 1'b1;
            if (timeout_cnt_q != 16'hFFFF) timeout_cnt_q <= timeout_cnt_q + 16'd1;
            state_q       <= S_RESP;
          end else begin
            wait_cnt_q <= wait_cnt_d;
          end
        end
        S_LOCAL: begin
          rsp_rdata_q <= '0;
`ifdef DRP_SEL_SHADOW_EN
          // A selector write clears the other three words, mirroring the mux.
          if (drpwe_q) begin
            shadow_q                 <= '0;
            shadow_q[drpaddr_q[1:0]] <= drpdi_q;
          end else begin
            rsp_rdata_q <= shadow_q[drpaddr_q[1:0]];
          end
`endif
          rsp_timeout_q <= 1'b0;
          rsp_valid_q   <= 1'b1;
          state_q       <= S_RESP;
        end
        S_RESP: begin
          rsp_valid_q   <= 1'b0;
          rsp_timeout_q <= 1'b0;
          drpwe_q       <= 1'b0;
          int_reg_q     <= 1'b0;
          req_ready_q   <= 1'b1;
          state_q       <= S_IDLE;
        end
        default: begin
          req_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_timeout = rsp_timeout_q;
  assign drpaddr     = drpaddr_q;
  assign drpdi       = drpdi_q;
  assign drpwe       = drpwe_q;
  assign drpen       = drpen_q;
  assign int_reg     = int_reg_q;
  assign busy        = (state_q != S_IDLE);
  assign timeout_cnt = timeout_cnt_q;

endmodule

// File: tb/tb_drp_master_fsm.sv
// Directed bench for drp_master_fsm with a short timeout (16 cycles); expected values are hand-derived.
module tb_drp_master_fsm;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic        req_we;
  logic        req_int_reg;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_timeout;
  logic [8:0]  drpaddr;
  logic [31:0] drpdi;
  logic        drpwe;
  logic        drpen;
  logic        int_reg;
  logic [31:0] drpdo;
  logic        drprdy;
  logic        busy;
  logic [15:0] timeout_cnt;

  int n_chk;
  int n_fail;

  drp_master_fsm #(
    .AW_QUAD    (9),
    .TIMEOUT_CYC(16),
    .TO_PATTERN (32'hDEAD_DEAD)
  ) dut (
    .drp_clk    (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_we     (req_we),
    .req_int_reg(req_int_reg),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_timeout(rsp_timeout),
    .drpaddr    (drpaddr),
    .drpdi      (drpdi),
    .drpwe      (drpwe),
    .drpen      (drpen),
    .int_reg    (int_reg),
    .drpdo      (drpdo),
    .drprdy     (drprdy),
    .busy       (busy),
    .timeout_cnt(timeout_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshake in the current cycle; returns in the drpen cycle.
  task automatic issue(input logic [8:0] a, input logic [31:0] d, input logic we, input logic ir);
    req_addr    = a;
    req_wdata   = d;
    req_we      = we;
    req_int_reg = ir;
    req_valid   = 1'b1;
    tick();
    req_valid   = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_wdata = '0;
    req_we = 1'b0; req_int_reg = 1'b0; drpdo = '0; drprdy = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    check("rst_ready",   32'(req_ready),   32'd1);
    check("rst_busy",    32'(busy),        32'd0);
    check("rst_drpen",   32'(drpen),       32'd0);
    check("rst_rspv",    32'(rsp_valid),   32'd0);
    check("rst_tocnt",   32'(timeout_cnt), 32'd0);

    // Read, drprdy 5 cycles after drpen
    issue(9'h012, 32'h0, 1'b0, 1'b1);
    check("rd_drpen",    32'(drpen),   32'd1);
    check("rd_addr",     32'(drpaddr), 32'h012);
    check("rd_intreg",   32'(int_reg), 32'd1);
    check("rd_ready",    32'(req_ready), 32'd0);
    check("rd_busy",     32'(busy),    32'd1);
    repeat (4) tick();
    check("rd_drpen_lo", 32'(drpen),   32'd0);
    check("rd_addr_hold",32'(drpaddr), 32'h012);
    tick();
    check("rd_no_rsp",   32'(rsp_valid), 32'd0);
    drprdy = 1'b1; drpdo = 32'h0000_ABCD;
    tick();
    drprdy = 1'b0; drpdo = '0;
    check("rd_rspv",     32'(rsp_valid),   32'd1);
    check("rd_rdata",    rsp_rdata,        32'h0000_ABCD);
    check("rd_to",       32'(rsp_timeout), 32'd0);
    check("rd_ir_resp",  32'(int_reg),     32'd1);
    tick();
    check("rd_rspv_lo",  32'(rsp_valid), 32'd0);
    check("rd_ready_hi", 32'(req_ready), 32'd1);
    check("rd_ir_clr",   32'(int_reg),   32'd0);

    // Write, drprdy 2 cycles after drpen
    issue(9'h020, 32'h1234_5678, 1'b1, 1'b0);
    check("wr_drpen",    32'(drpen), 32'd1);
    check("wr_we",       32'(drpwe), 32'd1);
    check("wr_di",       drpdi,      32'h1234_5678);
    tick();
    check("wr_we_hold",  32'(drpwe), 32'd1);
    check("wr_di_hold",  drpdi,      32'h1234_5678);
    tick();
    drprdy = 1'b1; drpdo = 32'hFFFF_FFFF;
    tick();
    drprdy = 1'b0; drpdo = '0;
    check("wr_rspv",     32'(rsp_valid), 32'd1);
    check("wr_rdata",    rsp_rdata,      32'h0);
    check("wr_we_resp",  32'(drpwe),     32'd1);
    tick();
    check("wr_we_clr",   32'(drpwe),     32'd0);
    check("wr_ready",    32'(req_ready), 32'd1);

    // Timeout: no drprdy, response at drpen+16
    issue(9'h040, 32'h0, 1'b0, 1'b0);
    repeat (15) tick();
    check("to_early",    32'(rsp_valid), 32'd0);
    check("to_busy",     32'(busy),      32'd1);
    tick();
    check("to_rspv",     32'(rsp_valid),   32'd1);
    check("to_rdata",    rsp_rdata,        32'hDEAD_DEAD);
    check("to_flag",     32'(rsp_timeout), 32'd1);
    check("to_cnt",      32'(timeout_cnt), 32'd1);
    drprdy = 1'b1; drpdo = 32'h1111_1111;
    tick();
    tick();
    drprdy = 1'b0; drpdo = '0;
    check("to_late_rspv",32'(rsp_valid),   32'd0);
    check("to_late_busy",32'(busy),        32'd0);
    check("to_late_cnt", 32'(timeout_cnt), 32'd1);

    // Selector write completes locally; next request held during RESP
    issue(9'h1FD, 32'h3, 1'b1, 1'b0);
    check("sw_drpen",    32'(drpen), 32'd1);
    tick();
    check("sw_no_rsp",   32'(rsp_valid), 32'd0);
    tick();
    check("sw_rspv",     32'(rsp_valid),   32'd1);
    check("sw_rdata",    rsp_rdata,        32'h0);
    check("sw_to",       32'(rsp_timeout), 32'd0);
    req_addr = 9'h012; req_wdata = '0; req_we = 1'b0; req_int_reg = 1'b0;
    req_valid = 1'b1;
    tick();
    check("b2b_ready",   32'(req_ready), 32'd1);
    check("b2b_no_en",   32'(drpen),     32'd0);
    tick();
    req_valid = 1'b0;
    check("b2b_drpen",   32'(drpen),     32'd1);
    check("b2b_addr",    32'(drpaddr),   32'h012);

    // drprdy exactly at the terminal count wins over the timeout
    repeat (15) tick();
    check("tc_no_rsp",   32'(rsp_valid), 32'd0);
    drprdy = 1'b1; drpdo = 32'h5A5A_0001;
    tick();
    drprdy = 1'b0; drpdo = '0;
    check("tc_rspv",     32'(rsp_valid),   32'd1);
    check("tc_to",       32'(rsp_timeout), 32'd0);
    check("tc_rdata",    rsp_rdata,        32'h5A5A_0001);
    check("tc_cnt",      32'(timeout_cnt), 32'd1);
    tick();

    // Selector reads
    issue(9'h1FD, 32'h0, 1'b0, 1'b0);
`ifdef DRP_SEL_SHADOW_EN
    tick();
    tick();
    check("sr1_rspv",    32'(rsp_valid), 32'd1);
    check("sr1_rdata",   rsp_rdata,      32'h3);
    tick();
    issue(9'h1FC, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    check("sr0_rspv",    32'(rsp_valid), 32'd1);
    check("sr0_rdata",   rsp_rdata,      32'h0);
    tick();
`else
    tick();
    tick();
    check("sr_wait",     32'(rsp_valid), 32'd0);
    check("sr_busy",     32'(busy),      32'd1);
    tick();
    drprdy = 1'b1; drpdo = 32'h0000_0077;
    tick();
    drprdy = 1'b0; drpdo = '0;
    check("sr_rspv",     32'(rsp_valid), 32'd1);
    check("sr_rdata",    rsp_rdata,      32'h0000_0077);
    tick();
`endif

    // Reset in the middle of WAIT
    issue(9'h080, 32'h0, 1'b0, 1'b0);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check("rs_drpen",    32'(drpen),       32'd0);
    check("rs_rspv",     32'(rsp_valid),   32'd0);
    check("rs_busy",     32'(busy),        32'd0);
    check("rs_ready",    32'(req_ready),   32'd1);
    check("rs_tocnt",    32'(timeout_cnt), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    drprdy = 1'b1; drpdo = 32'h9999_9999;
    tick();
    drprdy = 1'b0; drpdo = '0;
    for (int i = 0; i < 3; i++) begin
      check("rs_no_rsp",  32'(rsp_valid), 32'd0);
      check("rs_idle",    32'(busy),      32'd0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
